axis_pkt_stats: RTL and testbench
=================================

// Module: axis_pkt_stats
// PURPOSE
//  Passive multi-channel AXI4-Stream packet/byte statistics tap with an AXI4-Lite readout.
//  Replaces per-endpoint pktcount outputs on stimulus and sink blocks with one parametrised monitor.
//  Sits beside the DUT, snooping any number of stream interfaces, e.g. DUT input and DUT output.
//  Never drives stream signals; software or the bench reads counters over s_axi_control.
// PARAMETERS
//  NUM_CH     2    number of monitored stream channels (1..8)
//  DATA_W     512  stream TDATA width; KEEP_W = DATA_W/8
//  CNT_W      32   packet/byte/max-length counter width (<=32)
//  ADDR_W     8    AXI4-Lite address width
// PORTS
//  clk                    in   1             single clock for stream and AXI4-Lite
//  rst                    in   1             synchronous, active-high reset
//  mon_tvalid             in   NUM_CH        per-channel TVALID tap
//  mon_tready             in   NUM_CH        per-channel TREADY tap
//  mon_tkeep              in   NUM_CH*KEEP_W per-channel TKEEP tap, ch0 in LSBs
//  mon_tlast              in   NUM_CH        per-channel TLAST tap
//  s_axi_control_AW*/W*/B*/AR*/R*  AXI4-Lite slave, 32-bit data, ADDR_W address
// BEHAVIOUR
//  - Reset: all counters 0; in_pkt 0; AWREADY/WREADY/BVALID/ARREADY/RVALID 0; BRESP/RRESP 0.
//  - A beat is tvalid&tready on a channel; beat bytes = popcount(tkeep), 0..KEEP_W.
//  - Per beat: byte_cnt += bytes; cur_len += bytes; in_pkt <= !tlast.
//  - When tlast is set: pkt_cnt += 1; max_len <= max(max_len, cur_len+bytes); cur_len <= 0.
//  - All counters saturate at 2^CNT_W-1; no wrap.
//  - Counter update is visible on reads issued the cycle after the beat (1-cycle latency).
//  - CTRL.clear (bit0, write-1, self-clearing) zeroes every counter and cur_len/in_pkt next cycle.
//    A beat in the same cycle as clear is discarded.
//  - CTRL.freeze (bit1, R/W) holds all counters while cur_len keeps tracking the packet.
//    max_len is not updated for packets ending while frozen.
//  - AXI-Lite write: AWREADY and WREADY pulse together for one cycle when AWVALID&WVALID&!BVALID.
//    BVALID is set the following cycle and held until BREADY. BRESP=OKAY always.
//    Writes outside CTRL are ignored.
//  - AXI-Lite read: ARREADY pulses one cycle when ARVALID&!RVALID. RDATA/RVALID follow next cycle.
//    RVALID holds until RREADY. RRESP=OKAY; unmapped addresses read 0.
//  - One outstanding read and one outstanding write; a read and a write may complete in the same cycle.
//  - Register map:
//    0x00 ID = 32'h5354_0001 | NUM_CH<<8
//    0x04 CTRL
//    0x10+ch*0x10: +0 pkt_cnt, +4 byte_cnt, +8 max_len, +C status
//    Status: bit0 in_pkt, [31:16] err_cnt.
//  - Reset mid-packet: cur_len and in_pkt clear; the next beat counts as the start of a new packet.
// CONFIGURATION
//  - AXIS_PKT_STATS_ERR_EN defined: per-channel 16-bit saturating err_cnt is present.
//    err_cnt increments on a beat with !tlast and tkeep != all-ones, or on any beat with tkeep == 0.
//    Cleared by CTRL.clear and held while CTRL.freeze is set.
//  - AXIS_PKT_STATS_ERR_EN undefined: err_cnt logic is absent and status[31:16] reads 0.
// STRUCTURE
//  - Package axis_pkt_stats_pkg: register offsets, ID constant, CTRL bit indices.
//    Also popcount function parametrised on KEEP_W.
//  - Sub-module axis_pkt_stats_ch: one channel's counters and in_pkt state, instanced NUM_CH times by generate.
//  - Top holds the AXI-Lite FSMs and the read mux.
// TESTING
//  1 Reset, read 0x00 with NUM_CH=2 -> 32'h5354_0201; read 0x10..0x2C -> all 0.
//  2 ch0: 3 packets of 64B + 64B + 10B (tkeep last = 10'h3FF)
//    -> pkt_cnt=3, byte_cnt=414, max_len=138.
//  3 ch1: tvalid held with tready=0 for 20 cycles, then 1 beat with tlast
//    -> pkt_cnt=1, byte_cnt=64; stalled cycles not counted.
//  4 Write CTRL=1 in the same cycle as a ch0 last beat
//    -> all counters 0, beat dropped, CTRL reads 0.
//  5 Preload pkt_cnt near saturation (CNT_W=4 build), send 20 packets
//    -> pkt_cnt=15, holds at 15.
//  6 ERR_EN build: non-last beat with tkeep=64'h0F -> status=32'h0001_0001;
//    non-ERR_EN build -> status=32'h0000_0001.

Source files
------------

// File: rtl/axis_pkt_stats_pkg.sv
// Shared constants for the AXI4-Stream packet statistics tap: register map,
// ID value, CTRL bit positions, AXI-Lite handshake states and the TKEEP popcount.
package axis_pkt_stats_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned MAX_KEEP_W  = 128;  // widest TKEEP the popcount accepts
  localparam int unsigned LEN_W       = 8;    // beat byte count, holds 0..MAX_KEEP_W
  localparam int unsigned ERR_W       = 16;

  localparam logic [7:0] REG_ID      = 8'h00;
  localparam logic [7:0] REG_CTRL    = 8'h04;

  // Word offsets inside a channel's 16-byte block
  localparam logic [1:0] CH_PKT    = 2'd0;
  localparam logic [1:0] CH_BYTE   = 2'd1;
  localparam logic [1:0] CH_MAX    = 2'd2;
  localparam logic [1:0] CH_STATUS = 2'd3;

  localparam logic [AXIL_DATA_W-1:0] ID_BASE = 32'h5354_0001;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    AXI_IDLE,
    AXI_ACCEPT,
    AXI_RESP
  } axi_state_e;

  // Number of set TKEEP bits; narrower keeps are zero-extended by the caller.
  function automatic logic [LEN_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_KEEP_W); i++) n = n + LEN_W'(keep[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_pkt_stats_ch.sv
// One monitored stream channel: saturating packet/byte/max-length counters,
// running packet length and in-packet flag.
// Optional per-channel error counter when AXIS_PKT_STATS_ERR_EN is defined.
// Ports: clk, rst (sync, active-high), clear/freeze from CTRL,
//        tvalid/tready/tkeep/tlast tap, counter and status outputs.
module axis_pkt_stats_ch
  import axis_pkt_stats_pkg::*;
#(
  parameter int unsigned KEEP_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              freeze,
  input  logic              tvalid,
  input  logic              tready,
  input  logic [KEEP_W-1:0] tkeep,
  input  logic              tlast,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [CNT_W-1:0]  max_len,
  output logic              in_pkt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  // Add with saturation at 2^CNT_W-1
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SAT) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic             beat;
  logic [LEN_W-1:0] bytes;
  logic [CNT_W-1:0] cur_len;
  logic [CNT_W-1:0] pkt_len;

  assign beat    = tvalid & tready;
  assign bytes   = popcount(MAX_KEEP_W'(tkeep));
  assign pkt_len = sat_add(cur_len, bytes);

  // cur_len/in_pkt track every beat; counters hold while frozen
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
      max_len  <= '0;
      cur_len  <= '0;
      in_pkt   <= 1'b0;
    end else if (beat) begin
      cur_len <= tlast ? '0 : pkt_len;
      in_pkt  <= !tlast;
      if (!freeze) begin
        byte_cnt <= sat_add(byte_cnt, bytes);
        if (tlast) begin
          pkt_cnt <= sat_add(pkt_cnt, LEN_W'(1));
          if (pkt_len > max_len) max_len <= pkt_len;
        end
      end
    end
  end

`ifdef AXIS_PKT_STATS_ERR_EN
  logic keep_err;

  // Partial keep mid-packet, or an empty beat anywhere
  assign keep_err = (!tlast && (tkeep != {KEEP_W{1'b1}})) || (tkeep == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt <= '0;
    end else if (beat && keep_err && !freeze && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: rtl/axis_pkt_stats.sv
// Passive multi-channel AXI4-Stream packet/byte statistics tap with AXI4-Lite readout.
// Ports: clk, rst (sync, active-high); mon_tvalid/tready/tkeep/tlast taps (ch0 in LSBs);
//        s_axi_control_* AXI4-Lite slave (32-bit data, ADDR_W address).
// Build option: AXIS_PKT_STATS_ERR_EN adds per-channel err_cnt in status[31:16].
module axis_pkt_stats
  import axis_pkt_stats_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  parameter  int unsigned DATA_W = 512,
  parameter  int unsigned CNT_W  = 32,
  parameter  int unsigned ADDR_W = 8,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        mon_tvalid,
  input  logic [NUM_CH-1:0]        mon_tready,
  input  logic [NUM_CH*KEEP_W-1:0] mon_tkeep,
  input  logic [NUM_CH-1:0]        mon_tlast,
  input  logic [ADDR_W-1:0]        s_axi_control_awaddr,
  input  logic                     s_axi_control_awvalid,
  output logic                     s_axi_control_awready,
  input  logic [AXIL_DATA_W-1:0]   s_axi_control_wdata,
  input  logic [3:0]               s_axi_control_wstrb,
  input  logic                     s_axi_control_wvalid,
  output logic                     s_axi_control_wready,
  output logic [1:0]               s_axi_control_bresp,
  output logic                     s_axi_control_bvalid,
  input  logic                     s_axi_control_bready,
  input  logic [ADDR_W-1:0]        s_axi_control_araddr,
  input  logic                     s_axi_control_arvalid,
  output logic                     s_axi_control_arready,
  output logic [AXIL_DATA_W-1:0]   s_axi_control_rdata,
  output logic [1:0]               s_axi_control_rresp,
  output logic                     s_axi_control_rvalid,
  input  logic                     s_axi_control_rready
);

  axi_state_e wr_state;
  axi_state_e rd_state;
  logic       aw_w_ready;
  logic       wr_fire;
  logic       ctrl_hit;
  logic       clear;
  logic       freeze;

  logic [CNT_W-1:0] pkt_cnt  [NUM_CH];
  logic [CNT_W-1:0] byte_cnt [NUM_CH];
  logic [CNT_W-1:0] max_len  [NUM_CH];
  logic             in_pkt   [NUM_CH];
  logic [ERR_W-1:0] err_cnt  [NUM_CH];

  logic [ADDR_W-5:0]      rd_region;
  logic [1:0]             rd_off;
  logic [AXIL_DATA_W-1:0] rd_mux;

  logic unused_bits;
  assign unused_bits = ^{s_axi_control_wdata[AXIL_DATA_W-1:2], s_axi_control_wstrb[3:1],
                         s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    axis_pkt_stats_ch #(
      .KEEP_W(KEEP_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .freeze  (freeze),
      .tvalid  (mon_tvalid[g]),
      .tready  (mon_tready[g]),
      .tkeep   (mon_tkeep[g*KEEP_W +: KEEP_W]),
      .tlast   (mon_tlast[g]),
      .pkt_cnt (pkt_cnt[g]),
      .byte_cnt(byte_cnt[g]),
      .max_len (max_len[g]),
      .in_pkt  (in_pkt[g]),
      .err_cnt (err_cnt[g])
    );
  end

  assign s_axi_control_awready = aw_w_ready;
  assign s_axi_control_wready  = aw_w_ready;

  assign wr_fire  = aw_w_ready & s_axi_control_awvalid & s_axi_control_wvalid;
  assign ctrl_hit = ({s_axi_control_awaddr[ADDR_W-1:2], 2'b00} == ADDR_W'(REG_CTRL))
                    && s_axi_control_wstrb[0];
  // Clear acts on the handshake cycle so a beat in that same cycle is dropped
  assign clear    = wr_fire & ctrl_hit & s_axi_control_wdata[CTRL_CLEAR];

  // Write channel: accept AW+W together, then hold BVALID until BREADY
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state             <= AXI_IDLE;
      aw_w_ready           <= 1'b0;
      s_axi_control_bvalid <= 1'b0;
      s_axi_control_bresp  <= RESP_OKAY;
      freeze               <= 1'b0;
    end else begin
      s_axi_control_bresp <= RESP_OKAY;
      case (wr_state)
        AXI_IDLE: begin
          if (s_axi_control_awvalid && s_axi_control_wvalid) begin
            aw_w_ready <= 1'b1;
            wr_state   <= AXI_ACCEPT;
          end
        end
        AXI_ACCEPT: begin
          aw_w_ready           <= 1'b0;
          s_axi_control_bvalid <= 1'b1;
          wr_state             <= AXI_RESP;
          if (wr_fire && ctrl_hit) freeze <= s_axi_control_wdata[CTRL_FREEZE];
        end
        AXI_RESP: begin
          if (s_axi_control_bready) begin
            s_axi_control_bvalid <= 1'b0;
            wr_state             <= AXI_IDLE;
          end
        end
        default: wr_state <= AXI_IDLE;
      endcase
    end
  end

  assign rd_region = s_axi_control_araddr[ADDR_W-1:4];
  assign rd_off    = s_axi_control_araddr[3:2];

  // Read mux: region 0 holds ID/CTRL, region ch+1 holds that channel's block
  always_comb begin
    rd_mux = '0;
    if (rd_region == '0) begin
      case ({rd_off, 2'b00})
        REG_ID[3:0]:   rd_mux = ID_BASE | (AXIL_DATA_W'(NUM_CH) << 8);
        REG_CTRL[3:0]: rd_mux = {30'd0, freeze, 1'b0};
        default:       rd_mux = '0;
      endcase
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rd_region == (ADDR_W-4)'(i + 1)) begin
        case (rd_off)
          CH_PKT:    rd_mux = AXIL_DATA_W'(pkt_cnt[i]);
          CH_BYTE:   rd_mux = AXIL_DATA_W'(byte_cnt[i]);
          CH_MAX:    rd_mux = AXIL_DATA_W'(max_len[i]);
          CH_STATUS: rd_mux = {err_cnt[i], 15'd0, in_pkt[i]};
          default:   rd_mux = '0;
        endcase
      end
    end
  end

  // Read channel: ARREADY pulse, then RDATA/RVALID held until RREADY
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state              <= AXI_IDLE;
      s_axi_control_arready <= 1'b0;
      s_axi_control_rvalid  <= 1'b0;
      s_axi_control_rdata   <= '0;
      s_axi_control_rresp   <= RESP_OKAY;
    end else begin
      s_axi_control_rresp <= RESP_OKAY;
      case (rd_state)
        AXI_IDLE: begin
          if (s_axi_control_arvalid) begin
            s_axi_control_arready <= 1'b1;
            rd_state              <= AXI_ACCEPT;
          end
        end
        AXI_ACCEPT: begin
          s_axi_control_arready <= 1'b0;
          s_axi_control_rvalid  <= 1'b1;
          s_axi_control_rdata   <= rd_mux;
          rd_state              <= AXI_RESP;
        end
        AXI_RESP: begin
          if (s_axi_control_rready) begin
            s_axi_control_rvalid <= 1'b0;
            rd_state             <= AXI_IDLE;
          end
        end
        default: rd_state <= AXI_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_stats.sv
// Bench for axis_pkt_stats: a 32-bit-counter instance and a 4-bit-counter instance
// share the stream taps; the AXI-Lite bus is steered to one of them by sel.
module tb_axis_pkt_stats;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned ADDR_W = 8;
`ifdef AXIS_PKT_STATS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        tvalid, tready, tlast;
  logic [NUM_CH*KEEP_W-1:0] tkeep;

  logic [ADDR_W-1:0] awaddr, araddr;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  bit                sel;

  logic        awready_o [2];
  logic        wready_o  [2];
  logic        bvalid_o  [2];
  logic        arready_o [2];
  logic        rvalid_o  [2];
  logic [1:0]  bresp_o   [2];
  logic [1:0]  rresp_o   [2];
  logic [31:0] rdata_o   [2];

  axis_pkt_stats #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(32), .ADDR_W(ADDR_W)) dut0 (
    .clk(clk), .rst(rst),
    .mon_tvalid(tvalid), .mon_tready(tready), .mon_tkeep(tkeep), .mon_tlast(tlast),
    .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid && !sel),
    .s_axi_control_awready(awready_o[0]),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_wvalid(wvalid && !sel), .s_axi_control_wready(wready_o[0]),
    .s_axi_control_bresp(bresp_o[0]), .s_axi_control_bvalid(bvalid_o[0]),
    .s_axi_control_bready(bready),
    .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid && !sel),
    .s_axi_control_arready(arready_o[0]),
    .s_axi_control_rdata(rdata_o[0]), .s_axi_control_rresp(rresp_o[0]),
    .s_axi_control_rvalid(rvalid_o[0]), .s_axi_control_rready(rready)
  );

  axis_pkt_stats #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(4), .ADDR_W(ADDR_W)) dut1 (
    .clk(clk), .rst(rst),
    .mon_tvalid(tvalid), .mon_tready(tready), .mon_tkeep(tkeep), .mon_tlast(tlast),
    .s_axi_control_awaddr(awaddr), .s_axi_control_awvalid(awvalid && sel),
    .s_axi_control_awready(awready_o[1]),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_wvalid(wvalid && sel), .s_axi_control_wready(wready_o[1]),
    .s_axi_control_bresp(bresp_o[1]), .s_axi_control_bvalid(bvalid_o[1]),
    .s_axi_control_bready(bready),
    .s_axi_control_araddr(araddr), .s_axi_control_arvalid(arvalid && sel),
    .s_axi_control_arready(arready_o[1]),
    .s_axi_control_rdata(rdata_o[1]), .s_axi_control_rresp(rresp_o[1]),
    .s_axi_control_rvalid(rvalid_o[1]), .s_axi_control_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int ch, input logic [KEEP_W-1:0] keep, input logic last);
    tvalid[ch] = 1'b1;
    tready[ch] = 1'b1;
    tkeep[ch*KEEP_W +: KEEP_W] = keep;
    tlast[ch] = last;
    @(posedge clk); #1;
    tvalid = '0;
    tready = '0;
    tlast  = '0;
    tkeep  = '0;
  endtask

  // Expected value queued at issue, popped and compared when RVALID appears
  task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string tag);
    int   n;
    exp_t e;
    sb.push_back('{tag, exp});
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready_o[sel] && n < 16);
    check({tag, "_arready"}, 32'(arready_o[sel]), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid_o[sel] && n < 16) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    check(e.tag, rdata_o[sel], e.exp);
    check({tag, "_rresp"}, 32'(rresp_o[sel]), 32'd0);
    @(posedge clk); #1;
  endtask

  // Optional ch0 last beat placed in the write handshake cycle
  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input bit with_beat);
    int n;
    awaddr  = addr;
    wdata   = data;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready_o[sel] && n < 16);
    check("wr_awready", 32'(awready_o[sel] & wready_o[sel]), 32'd1);
    if (with_beat) begin
      tvalid[0] = 1'b1;
      tready[0] = 1'b1;
      tkeep[KEEP_W-1:0] = '1;
      tlast[0] = 1'b1;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tvalid  = '0;
    tready  = '0;
    tlast   = '0;
    tkeep   = '0;
    n = 0;
    while (!bvalid_o[sel] && n < 16) begin @(posedge clk); #1; n++; end
    check("wr_bvalid_bresp", {bresp_o[sel], 29'd0, bvalid_o[sel]}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    tvalid = '0; tready = '0; tlast = '0; tkeep = '0;
    awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_valid", {31'd0, awready_o[0] | wready_o[0] | bvalid_o[0] |
                                     arready_o[0] | rvalid_o[0]}, 32'd0);
    rst = 1'b0;

    // Reset state and ID
    rd(8'h00, 32'h5354_0201, "id");
    rd(8'h04, 32'h0, "ctrl_rst");
    for (int a = 'h10; a <= 'h2C; a += 4) rd(8'(a), 32'h0, "rst_cnt");

    // ch0: three 138-byte packets
    for (int p = 0; p < 3; p++) begin
      beat(0, '1, 1'b0);
      beat(0, '1, 1'b0);
      beat(0, 64'h3FF, 1'b1);
    end
    rd(8'h10, 32'd3, "ch0_pkt");
    rd(8'h14, 32'd414, "ch0_byte");
    rd(8'h18, 32'd138, "ch0_max");
    rd(8'h1C, 32'd0, "ch0_status");

    // ch1: 20 stalled cycles then one accepted last beat
    tvalid[1] = 1'b1; tready[1] = 1'b0; tlast[1] = 1'b1;
    tkeep[KEEP_W +: KEEP_W] = '1;
    repeat (20) @(posedge clk);
    #1;
    tready[1] = 1'b1;
    @(posedge clk); #1;
    tvalid = '0; tready = '0; tlast = '0; tkeep = '0;
    rd(8'h20, 32'd1, "ch1_pkt");
    rd(8'h24, 32'd64, "ch1_byte");
    rd(8'h28, 32'd64, "ch1_max");
    rd(8'h10, 32'd3, "ch0_pkt_kept");

    // Clear coinciding with a ch0 last beat
    wr(8'h04, 32'h1, 1'b1);
    rd(8'h10, 32'd0, "clr_ch0_pkt");
    rd(8'h14, 32'd0, "clr_ch0_byte");
    rd(8'h18, 32'd0, "clr_ch0_max");
    rd(8'h20, 32'd0, "clr_ch1_pkt");
    rd(8'h24, 32'd0, "clr_ch1_byte");
    rd(8'h04, 32'd0, "clr_ctrl");

    // 4-bit counter instance saturates
    sel = 1'b1;
    wr(8'h04, 32'h1, 1'b0);
    rd(8'h10, 32'd0, "sat_pkt_clr");
    repeat (20) beat(0, '1, 1'b1);
    rd(8'h10, 32'd15, "sat_pkt");
    rd(8'h14, 32'd15, "sat_byte");
    rd(8'h18, 32'd15, "sat_max");
    repeat (3) beat(0, '1, 1'b1);
    rd(8'h10, 32'd15, "sat_pkt_hold");
    sel = 1'b0;

    // Partial keep mid-packet
    wr(8'h04, 32'h1, 1'b0);
    beat(0, 64'h0F, 1'b0);
    rd(8'h1C, ERR_EN ? 32'h0001_0001 : 32'h0000_0001, "err_status");
    rd(8'h14, 32'd4, "err_byte");
    rd(8'h10, 32'd0, "err_pkt");

    // Freeze: counters hold, packet length keeps tracking
    wr(8'h04, 32'h2, 1'b0);
    rd(8'h04, 32'h2, "frz_ctrl");
    beat(0, '1, 1'b1);
    beat(0, '0, 1'b0);
    rd(8'h10, 32'd0, "frz_pkt");
    rd(8'h14, 32'd4, "frz_byte");
    rd(8'h18, 32'd0, "frz_max");
    rd(8'h1C, ERR_EN ? 32'h0001_0001 : 32'h0000_0001, "frz_status");
    wr(8'h04, 32'h0, 1'b0);
    beat(0, '1, 1'b1);
    rd(8'h10, 32'd1, "unfrz_pkt");
    rd(8'h14, 32'd68, "unfrz_byte");
    rd(8'h18, 32'd64, "unfrz_max");
    rd(8'h1C, ERR_EN ? 32'h0001_0000 : 32'h0000_0000, "unfrz_status");

    // Unmapped addresses
    rd(8'h08, 32'd0, "unmapped_08");
    rd(8'h30, 32'd0, "unmapped_30");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
